fetch_queue_stage: RTL and testbench

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

---
 rtl/fetch_queue_stage_if.sv | 29 ++
 rtl/fetch_queue_stage.sv | 89 ++++++++
 tb/tb_fetch_queue_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_stage_if.sv
// Fetch-to-decode bundle: redirect/stall control in, imem address/data, head-of-queue outputs.
// The fetch stage uses the master view; the decode/memory side uses the slave view.
interface fetch_queue_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            RedirectF;
  logic [XLEN-1:0] RedirectPC;
  logic            StallD;
  logic [XLEN-1:0] ImemAddr;
  logic [XLEN-1:0] ImemRdata;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic [CW-1:0]   Count;

  modport master (
    input  RedirectF, RedirectPC, StallD, ImemRdata,
    output ImemAddr, InstrD, PCD, PCPlus4D, ValidD, Count
  );

  modport slave (
    output RedirectF, RedirectPC, StallD, ImemRdata,
    input  ImemAddr, InstrD, PCD, PCPlus4D, ValidD, Count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch PC plus DEPTH-entry {PC, instr} queue; an entry pushed at an edge is at the head right after it.
// Full queue stops fetching unless the head pops that cycle; a redirect flushes and reloads the PC.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input logic                 CLK,
  input logic                 RST,
  fetch_queue_stage_if.master bus
);
  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic valid;
  logic pop;
  logic push;

  assign valid = (count_q != '0);
  assign pop   = valid & ~bus.StallD & ~bus.RedirectF;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push  = ~bus.RedirectF & ((count_q < FULL) | pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.RedirectF) begin
      pc_d     = bus.RedirectPC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        pc_d     = pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never observed while invalid, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= bus.ImemRdata;
    end
  end

  assign bus.ImemAddr = pc_q;
  assign bus.ValidD   = valid;
  assign bus.Count    = count_q;
  assign bus.InstrD   = valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.PCD      = valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.PCPlus4D = valid ? (pc_mem_q[rd_ptr_q] + STEP) : '0;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: memory returns word = address; outputs sampled 1ns after each rising edge.
module tb_fetch_queue_stage;
  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  fetch_queue_stage_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_queue_stage #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  assign bus.ImemRdata = bus.ImemAddr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b0;
    bus.RedirectF  = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.StallD     = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(bus.ValidD), 32'd0);
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_addr", bus.ImemAddr, 32'h0);
    chk("rst_pcd", bus.PCD, 32'h0);
    chk("rst_instr", bus.InstrD, 32'h0);
    chk("rst_pcplus4", bus.PCPlus4D, 32'h0);
    RST = 1'b1;

    // Streaming, no stall: one instruction per cycle, Count stays 1
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_pcd", bus.PCD, 32'(4 * i));
      chk("stream_instr", bus.InstrD, 32'(4 * i));
      chk("stream_pcplus4", bus.PCPlus4D, 32'(4 * i + 4));
      chk("stream_valid", 32'(bus.ValidD), 32'd1);
      chk("stream_count", 32'(bus.Count), 32'd1);
    end
    chk("stream_addr", bus.ImemAddr, 32'h10);

    // Stall one cycle to reach Count=2, then pulse reset between edges
    bus.StallD = 1'b1;
    tick();
    chk("pre_rst_count", 32'(bus.Count), 32'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.Count), 32'd0);
    chk("async_rst_valid", 32'(bus.ValidD), 32'd0);
    chk("async_rst_pcd", bus.PCD, 32'h0);
    chk("async_rst_instr", bus.InstrD, 32'h0);
    chk("async_rst_addr", bus.ImemAddr, 32'h0);
    #1;
    RST = 1'b1;

    // Fill with decode stalled for 6 cycles
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("fill_count", 32'(bus.Count), (i < 4) ? 32'(i) : 32'd4);
      chk("fill_pcd", bus.PCD, 32'h0);
    end
    chk("full_addr_hold", bus.ImemAddr, 32'h10);

    // Release stall on a full queue: push and pop together, no bubble
    bus.StallD = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_pcd", bus.PCD, 32'(4 * i));
      chk("drain_count", 32'(bus.Count), 32'd4);
      chk("drain_addr", bus.ImemAddr, 32'(16 + 4 * i));
    end

    // Redirect, then build Count=3 under stall
    bus.RedirectF  = 1'b1;
    bus.RedirectPC = 32'h200;
    tick();
    chk("redir1_count", 32'(bus.Count), 32'd0);
    chk("redir1_addr", bus.ImemAddr, 32'h200);
    bus.RedirectF = 1'b0;
    bus.StallD    = 1'b1;
    tick();
    tick();
    tick();
    chk("three_count", 32'(bus.Count), 32'd3);
    chk("three_pcd", bus.PCD, 32'h200);

    // Redirect while stalled with Count=3
    bus.RedirectF  = 1'b1;
    bus.RedirectPC = 32'h100;
    tick();
    chk("redir2_count", 32'(bus.Count), 32'd0);
    chk("redir2_valid", 32'(bus.ValidD), 32'd0);
    chk("redir2_addr", bus.ImemAddr, 32'h100);
    chk("redir2_pcd", bus.PCD, 32'h0);
    bus.RedirectF = 1'b0;
    bus.StallD    = 1'b0;
    tick();
    chk("post_redir_pcd", bus.PCD, 32'h100);
    chk("post_redir_instr", bus.InstrD, 32'h100);
    chk("post_redir_valid", 32'(bus.ValidD), 32'd1);

    // Back-to-back redirects: the last target wins
    bus.RedirectF  = 1'b1;
    bus.RedirectPC = 32'h300;
    tick();
    bus.RedirectPC = 32'hFFFF_FFFC;
    tick();
    chk("b2b_count", 32'(bus.Count), 32'd0);
    chk("b2b_addr", bus.ImemAddr, 32'hFFFF_FFFC);

    // PC wrap at the top of the address space
    bus.RedirectF = 1'b0;
    tick();
    chk("wrap_pcd", bus.PCD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", bus.PCPlus4D, 32'h0);
    chk("wrap_addr", bus.ImemAddr, 32'h0);
    tick();
    chk("wrap_next_pcd", bus.PCD, 32'h0);
    chk("wrap_next_addr", bus.ImemAddr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
